program_counter: RTL

//   Holds the 64-bit PC and applies the per-cycle PC update requested by the

---
 rtl/program_counter.sv | 79 +++++++
 1 files changed

// File: rtl/program_counter.sv
// 64-bit program counter with branch/jump update, misaligned-target trap
// and a counter of accepted PC updates.
module program_counter #(
    parameter int unsigned     W        = 64,
    parameter logic [W-1:0]    RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       Psel,
    input  logic             PCsel,
    input  logic [W-1:0]     K,
    input  logic [W-1:0]     in,
    input  logic             stall,
    input  logic             EN_PC,
    output logic [W-1:0]     PC,
    output logic [W-1:0]     PC4,
    output logic [W-1:0]     bus_out,
    output logic             bus_drive,
    output logic             fault,
    output logic [W-1:0]     fault_pc,
    output logic [CNT_W-1:0] upd_count
);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   off;
    logic [W-1:0]   off_sh;
    logic [W-1:0]   next_pc;
    logic           misaligned;
    logic           accept;

    assign PC4       = PC + W'(4);
    assign bus_out   = EN_PC ? PC4 : '0;
    assign bus_drive = EN_PC;

    // Offsets are in words; the top two bits fall off the shift.
    assign off    = PCsel ? K : in;
    assign off_sh = {off[W-3:0], 2'b00};

    always_comb begin
        next_pc = PC;
        unique case (Psel)
            2'b00: next_pc = PC;
            2'b01: next_pc = PC4;
            2'b10: next_pc = in;
            2'b11: next_pc = PC4 + off_sh;
        endcase
    end

    assign misaligned = |next_pc[1:0];
    assign accept     = !stall && (state == RUN);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= RUN;
            PC        <= RESET_PC;
            fault     <= 1'b0;
            fault_pc  <= '0;
            upd_count <= '0;
        end else if (accept) begin
            if (misaligned) begin
                state    <= TRAP;
                fault    <= 1'b1;
                fault_pc <= PC;
            end else begin
                PC <= next_pc;
                if (Psel != 2'b00) begin
                    upd_count <= upd_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
